// File: rtl/conv_bram_sched_pkg.sv
// rtl/conv_bram_sched_pkg.sv - shared constants and state encoding for the column-buffer sequencer
package conv_bram_sched_pkg;

    localparam int NUM_BANKS      = 3;
    localparam int DEF_RAM_WIDTH  = 13;
    localparam int DEF_NB_ADDRESS = 10;
    localparam int DEF_NB_COLS    = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_SWEEP = 3'd2,
        ST_LOAD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/conv_bram_bank_ptr.sv
// rtl/conv_bram_bank_ptr.sv - mod-3 rotating bank pointer with one-hot write-enable decode
module conv_bram_bank_ptr
    import conv_bram_sched_pkg::*;
(
    input  logic                 i_CLK,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_advance,
    input  logic                 i_we,
    output logic [1:0]           o_ptr,
    output logic [NUM_BANKS-1:0] o_bank_we
);

    always_ff @(posedge i_CLK or negedge i_rst) begin
        if (!i_rst) begin
            o_ptr <= 2'd0;
        end else if (i_clear) begin
            o_ptr <= 2'd0;
        end else if (i_advance) begin
            o_ptr <= (o_ptr == 2'd2) ? 2'd0 : o_ptr + 2'd1;
        end
    end

    always_comb begin
        o_bank_we = '0;
        if (i_we) begin
            case (o_ptr)
                2'd0:    o_bank_we = 3'b001;
                2'd1:    o_bank_we = 3'b010;
                2'd2:    o_bank_we = 3'b100;
                default: o_bank_we = '0;
            endcase
        end
    end

endmodule

// File: rtl/conv_bram_sched.sv
// rtl/conv_bram_sched.sv - load/sweep sequencer for three column BRAM banks; optional stall via CONV_BRAM_SCHED_STALL_EN
module conv_bram_sched
    import conv_bram_sched_pkg::*;
#(
    parameter int RAM_WIDTH  = DEF_RAM_WIDTH,
    parameter int NB_ADDRESS = DEF_NB_ADDRESS,
    parameter int NB_COLS    = DEF_NB_COLS
) (
    input  logic                  i_CLK,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [NB_ADDRESS:0]   i_cfg_height,
    input  logic [NB_COLS-1:0]    i_cfg_width,
    input  logic                  i_wr_valid,
    input  logic [RAM_WIDTH-1:0]  i_wr_data,
`ifdef CONV_BRAM_SCHED_STALL_EN
    input  logic                  i_stall,
`endif
    output logic                  o_wr_ready,
    output logic [NUM_BANKS-1:0]  o_bank_we,
    output logic [NB_ADDRESS-1:0] o_wr_addr,
    output logic [RAM_WIDTH-1:0]  o_wr_data,
    output logic [NB_ADDRESS-1:0] o_rd_addr,
    output logic [1:0]            o_rd_sel,
    output logic                  o_conv_valid,
    output logic                  o_col_done,
    output logic                  o_frame_done,
    output logic                  o_cfg_err,
    output logic                  o_busy
);

    localparam logic [NB_ADDRESS:0]   H_MAX = {1'b1, {NB_ADDRESS{1'b0}}};
    localparam logic [NB_ADDRESS:0]   H_ONE = {{NB_ADDRESS{1'b0}}, 1'b1};
    localparam logic [NB_ADDRESS-1:0] A_ONE = {{(NB_ADDRESS-1){1'b0}}, 1'b1};
    localparam logic [NB_COLS-1:0]    C_ONE = NB_COLS'(1);
    localparam logic [NB_COLS-1:0]    C_TWO = NB_COLS'(2);
    localparam logic [NB_COLS-1:0]    W_MIN = NB_COLS'(3);

    state_t                state;
    logic [NB_ADDRESS:0]   row_cnt;
    logic [NB_ADDRESS:0]   h_last;
    logic [NB_COLS-1:0]    col_cnt;
    logic [NB_COLS-1:0]    cfg_width;
    logic [NB_ADDRESS-1:0] rd_addr;
    logic                  rd_issue;
    logic                  conv_valid;
    logic                  col_done;
    logic                  cfg_err;
    logic                  stall;
    logic                  wr_ready;
    logic                  accept;
    logic                  row_last;
    logic                  rd_last;
    logic                  cfg_ok;
    logic                  start_ok;
    logic [1:0]            bank_ptr;

`ifdef CONV_BRAM_SCHED_STALL_EN
    assign stall = i_stall;
`else
    assign stall = 1'b0;
`endif

    assign cfg_ok   = (i_cfg_height != '0) && (i_cfg_height <= H_MAX) && (i_cfg_width >= W_MIN);
    assign start_ok = (state == ST_IDLE) && i_start && cfg_ok;
    assign wr_ready = (state == ST_PRIME) || (state == ST_LOAD);
    assign accept   = wr_ready && i_wr_valid;
    // Row counter is one bit wider than the address so a full-depth column terminates correctly
    assign row_last = (row_cnt == h_last);
    assign rd_last  = ({1'b0, rd_addr} == h_last);

    conv_bram_bank_ptr u_bank_ptr (
        .i_CLK     (i_CLK),
        .i_rst     (i_rst),
        .i_clear   (start_ok),
        .i_advance (accept && row_last),
        .i_we      (accept),
        .o_ptr     (bank_ptr),
        .o_bank_we (o_bank_we)
    );

    always_ff @(posedge i_CLK or negedge i_rst) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            row_cnt    <= '0;
            h_last     <= '0;
            col_cnt    <= '0;
            cfg_width  <= '0;
            rd_addr    <= '0;
            rd_issue   <= 1'b0;
            conv_valid <= 1'b0;
            col_done   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (cfg_ok) begin
                            state     <= ST_PRIME;
                            h_last    <= i_cfg_height - H_ONE;
                            cfg_width <= i_cfg_width;
                            cfg_err   <= 1'b0;
                            row_cnt   <= '0;
                            col_cnt   <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_PRIME, ST_LOAD: begin
                    if (accept) begin
                        if (row_last) begin
                            row_cnt <= '0;
                            col_cnt <= col_cnt + C_ONE;
                            if ((state == ST_LOAD) || (col_cnt == C_TWO)) begin
                                state    <= ST_SWEEP;
                                rd_addr  <= '0;
                                rd_issue <= 1'b1;
                            end
                        end else begin
                            row_cnt <= row_cnt + H_ONE;
                        end
                    end
                end
                ST_SWEEP: begin
                    // A stall freezes the whole read pipe so the presented slice stays valid
                    if (!stall) begin
                        conv_valid <= rd_issue;
                        col_done   <= rd_issue && rd_last;
                        if (rd_issue) begin
                            if (rd_last) begin
                                rd_issue <= 1'b0;
                            end else begin
                                rd_addr <= rd_addr + A_ONE;
                            end
                        end
                        if (col_done) begin
                            state <= (col_cnt < cfg_width) ? ST_LOAD : ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_wr_ready   = wr_ready;
    assign o_wr_addr    = row_cnt[NB_ADDRESS-1:0];
    assign o_wr_data    = accept ? i_wr_data : '0;
    assign o_rd_addr    = rd_addr;
    assign o_rd_sel     = bank_ptr;
    assign o_conv_valid = conv_valid;
    assign o_col_done   = col_done;
    assign o_frame_done = (state == ST_DONE);
    assign o_cfg_err    = cfg_err;
    assign o_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_conv_bram_sched.sv
// tb/tb_conv_bram_sched.sv - directed table-driven bench for conv_bram_sched
module tb_conv_bram_sched;

    logic        i_CLK = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [10:0] i_cfg_height;
    logic [9:0]  i_cfg_width;
    logic        i_wr_valid;
    logic [12:0] i_wr_data;
`ifdef CONV_BRAM_SCHED_STALL_EN
    logic        i_stall;
`endif
    logic        o_wr_ready;
    logic [2:0]  o_bank_we;
    logic [9:0]  o_wr_addr;
    logic [12:0] o_wr_data;
    logic [9:0]  o_rd_addr;
    logic [1:0]  o_rd_sel;
    logic        o_conv_valid;
    logic        o_col_done;
    logic        o_frame_done;
    logic        o_cfg_err;
    logic        o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 i_CLK = ~i_CLK;

    conv_bram_sched dut (
`ifdef CONV_BRAM_SCHED_STALL_EN
        .i_stall      (i_stall),
`endif
        .i_CLK        (i_CLK),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_cfg_height (i_cfg_height),
        .i_cfg_width  (i_cfg_width),
        .i_wr_valid   (i_wr_valid),
        .i_wr_data    (i_wr_data),
        .o_wr_ready   (o_wr_ready),
        .o_bank_we    (o_bank_we),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_rd_addr    (o_rd_addr),
        .o_rd_sel     (o_rd_sel),
        .o_conv_valid (o_conv_valid),
        .o_col_done   (o_col_done),
        .o_frame_done (o_frame_done),
        .o_cfg_err    (o_cfg_err),
        .o_busy       (o_busy)
    );

    typedef struct {
        int h;
        int w;
        int mode;
        int exp_writes;
        int exp_sweeps;
        int exp_valids;
    } frame_vec_t;

    typedef struct {
        int h;
        int w;
        int exp_err;
    } cfg_vec_t;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr_ready"}, o_wr_ready, 0);
        check({tag, "_bank_we"}, o_bank_we, 0);
        check({tag, "_wr_addr"}, o_wr_addr, 0);
        check({tag, "_wr_data"}, o_wr_data, 0);
        check({tag, "_rd_addr"}, o_rd_addr, 0);
        check({tag, "_rd_sel"}, o_rd_sel, 0);
        check({tag, "_conv_valid"}, o_conv_valid, 0);
        check({tag, "_col_done"}, o_col_done, 0);
        check({tag, "_frame_done"}, o_frame_done, 0);
        check({tag, "_cfg_err"}, o_cfg_err, 0);
        check({tag, "_busy"}, o_busy, 0);
    endtask

    // Entered and left at #1 after a rising edge; mode 1 toggles valid and pokes i_start with bad cfg
    task automatic run_frame(input frame_vec_t v);
        int row, col, target, sc, sweep, nwr, nv, cyc, phase, limit;
        logic wv;
        row = 0; col = 0; target = 3; sc = 0; sweep = 0; nwr = 0; nv = 0; cyc = 0; phase = 0;
        limit = v.h * v.w * 3 + (v.h + 1) * v.w + 50;
        i_start = 1'b1; i_cfg_height = 11'(v.h); i_cfg_width = 10'(v.w); i_wr_valid = 1'b0;
        @(negedge i_CLK);
        check("start_busy_before", o_busy, 0);
        @(posedge i_CLK); #1;
        i_start = 1'b0;
        if (v.mode == 1) begin
            i_cfg_height = '0;
            i_cfg_width  = '0;
        end
        while (phase != 3 && cyc < limit) begin
            wv = (v.mode == 0) ? 1'b1 : cyc[0];
            i_wr_valid = wv;
            i_wr_data  = 13'($urandom);
            if (v.mode == 1) i_start = cyc[1];
            @(negedge i_CLK);
            check("cfg_err_clear", o_cfg_err, 0);
            check("busy", o_busy, 1);
            case (phase)
                0: begin
                    check("wr_ready_load", o_wr_ready, 1);
                    check("conv_valid_load", o_conv_valid, 0);
                    check("frame_done_load", o_frame_done, 0);
                    check("bank_we", o_bank_we, wv ? (1 << (col % 3)) : 0);
                    if (wv) begin
                        check("wr_addr", o_wr_addr, row);
                        check("wr_data", o_wr_data, i_wr_data);
                        nwr++;
                        row++;
                        if (row == v.h) begin
                            row = 0;
                            col++;
                            if (col == target) begin
                                phase = 1;
                                sc = 0;
                            end
                        end
                    end
                end
                1: begin
                    check("wr_ready_sweep", o_wr_ready, 0);
                    check("bank_we_sweep", o_bank_we, 0);
                    check("frame_done_sweep", o_frame_done, 0);
                    check("conv_valid", o_conv_valid, (sc >= 1) ? 1 : 0);
                    check("col_done", o_col_done, (sc == v.h) ? 1 : 0);
                    if (sc < v.h) check("rd_addr", o_rd_addr, sc);
                    if (o_conv_valid) begin
                        nv++;
                        check("rd_sel", o_rd_sel, sweep % 3);
                    end
                    if (sc == v.h) begin
                        sweep++;
                        if (col < v.w) begin
                            target = col + 1;
                            phase = 0;
                        end else begin
                            phase = 2;
                        end
                    end else begin
                        sc++;
                    end
                end
                default: begin
                    check("frame_done", o_frame_done, 1);
                    check("wr_ready_done", o_wr_ready, 0);
                    check("conv_valid_done", o_conv_valid, 0);
                    phase = 3;
                end
            endcase
            @(posedge i_CLK); #1;
            cyc++;
        end
        i_wr_valid = 1'b0;
        i_start    = 1'b0;
        check("frame_timeout", (phase == 3) ? 1 : 0, 1);
        check("frame_writes", nwr, v.exp_writes);
        check("frame_sweeps", sweep, v.exp_sweeps);
        check("frame_valids", nv, v.exp_valids);
        @(negedge i_CLK);
        check("idle_busy", o_busy, 0);
        check("idle_frame_done", o_frame_done, 0);
        @(posedge i_CLK); #1;
    endtask

    frame_vec_t frames[5];
    cfg_vec_t   cfgs[4];

    initial begin
        int  nv, cyc, sc;
        logic hit;

        frames[0] = '{h: 4,    w: 5, mode: 0, exp_writes: 20,   exp_sweeps: 3, exp_valids: 12};
        frames[1] = '{h: 4,    w: 5, mode: 1, exp_writes: 20,   exp_sweeps: 3, exp_valids: 12};
        frames[2] = '{h: 1,    w: 3, mode: 0, exp_writes: 3,    exp_sweeps: 1, exp_valids: 1};
        frames[3] = '{h: 1024, w: 3, mode: 0, exp_writes: 3072, exp_sweeps: 1, exp_valids: 1024};
        frames[4] = '{h: 2,    w: 4, mode: 1, exp_writes: 8,    exp_sweeps: 2, exp_valids: 4};

        cfgs[0] = '{h: 4,    w: 2, exp_err: 1};
        cfgs[1] = '{h: 0,    w: 5, exp_err: 1};
        cfgs[2] = '{h: 1025, w: 4, exp_err: 1};
        cfgs[3] = '{h: 4,    w: 0, exp_err: 1};

        i_rst = 1'b0; i_start = 1'b0; i_cfg_height = '0; i_cfg_width = '0;
        i_wr_valid = 1'b0; i_wr_data = '0;
`ifdef CONV_BRAM_SCHED_STALL_EN
        i_stall = 1'b0;
`endif
        repeat (2) @(posedge i_CLK);
        @(negedge i_CLK);
        check_idle_outputs("reset");
        @(posedge i_CLK); #1;
        i_rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            i_start = 1'b1; i_cfg_height = 11'(cfgs[i].h); i_cfg_width = 10'(cfgs[i].w);
            @(posedge i_CLK); #1;
            i_start = 1'b0;
            @(negedge i_CLK);
            check("cfg_err_set", o_cfg_err, cfgs[i].exp_err);
            check("cfg_err_busy", o_busy, 0);
            @(posedge i_CLK); #1;
        end

        for (int i = 0; i < 5; i++) run_frame(frames[i]);

        // Reset during the second sweep, then a fresh small frame
        i_start = 1'b1; i_cfg_height = 11'd4; i_cfg_width = 10'd5;
        @(posedge i_CLK); #1;
        i_start = 1'b0; i_wr_valid = 1'b1;
        nv = 0; cyc = 0;
        while (nv < 6 && cyc < 200) begin
            @(negedge i_CLK);
            if (o_conv_valid) nv++;
            @(posedge i_CLK); #1;
            cyc++;
        end
        check("mid_reset_reached", nv, 6);
        check("mid_reset_in_sweep", o_conv_valid, 1);
        i_rst = 1'b0;
        @(negedge i_CLK);
        check_idle_outputs("mid_reset");
        @(posedge i_CLK); #1;
        i_rst = 1'b1; i_wr_valid = 1'b0;
        run_frame('{h: 2, w: 3, mode: 0, exp_writes: 6, exp_sweeps: 1, exp_valids: 2});

`ifdef CONV_BRAM_SCHED_STALL_EN
        i_start = 1'b1; i_cfg_height = 11'd4; i_cfg_width = 10'd3;
        @(posedge i_CLK); #1;
        i_start = 1'b0; i_wr_valid = 1'b1;
        hit = 1'b0; cyc = 0;
        while (!hit && cyc < 100) begin
            @(negedge i_CLK);
            if (o_busy && !o_wr_ready) hit = 1'b1;
            else begin
                @(posedge i_CLK); #1;
                cyc++;
            end
        end
        check("stall_sweep_entry", hit, 1);
        check("stall_rd_addr0", o_rd_addr, 0);
        sc = 0; hit = 1'b0;
        while (!hit && sc < 20) begin
            @(posedge i_CLK); #1;
            sc++;
            i_wr_valid = 1'b0;
            i_stall = (sc >= 2 && sc <= 4);
            @(negedge i_CLK);
            check("stall_valid", o_conv_valid, 1);
            if (sc <= 6) check("stall_rd_addr", o_rd_addr, (sc < 2) ? sc : ((sc <= 5) ? 2 : 3));
            if (o_col_done) hit = 1'b1;
        end
        i_stall = 1'b0;
        check("stall_sweep_cycles", sc + 1, 8);
        @(posedge i_CLK); #1;
        @(negedge i_CLK);
        check("stall_frame_done", o_frame_done, 1);
        @(posedge i_CLK); #1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
